// File: rtl/isa_pkg.sv
//-----------------------------------------------------------------------------
// isa_pkg
// Shared definitions for the ISA bus master: the bus cycle-type encoding,
// the FSM state enum, the strobe bundle and helpers that map a cycle type to
// its strobe pattern and direction.
// Ports: none (package).
//-----------------------------------------------------------------------------
package isa_pkg;

   // Cycle type as presented on req_type.
   typedef enum logic [1:0] {
      CYC_IOR  = 2'b00,
      CYC_IOW  = 2'b01,
      CYC_MEMR = 2'b10,
      CYC_MEMW = 2'b11
   } cyc_type_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_STROBE,
      ST_WAIT,
      ST_HOLD
   } state_e;

   // Active-low command strobes, kept together so only one can ever be
   // selected at a time.
   typedef struct packed {
      logic ior_l;
      logic iow_l;
      logic memr_l;
      logic memw_l;
   } strobes_t;

   localparam strobes_t STROBES_IDLE = strobes_t'(4'hF);

   // Strobe pattern for one cycle type: exactly one strobe low.
   function automatic strobes_t strobe_for(input cyc_type_e t);
      strobes_t s;
      s = STROBES_IDLE;
      case (t)
         CYC_IOR:  s.ior_l  = 1'b0;
         CYC_IOW:  s.iow_l  = 1'b0;
         CYC_MEMR: s.memr_l = 1'b0;
         CYC_MEMW: s.memw_l = 1'b0;
      endcase
      return s;
   endfunction

   // Bit 0 of the encoding distinguishes writes from reads.
   function automatic logic is_write(input cyc_type_e t);
      return t[0];
   endfunction

endpackage

// File: rtl/isa_bus_master_if.sv
//-----------------------------------------------------------------------------
// isa_bus_master_if
// Bundles the command/response handshake and the ISA bus pins.
//   master modport : the bus master (drives strobes, address, response)
//   slave  modport : requester + bus responder side (drives requests, data,
//                    ready)
// Signals:
//   req_valid/req_ready/req_type/req_addr/req_wdata : command handshake
//   rsp_valid/rsp_rdata/rsp_timeout                 : completion report
//   bus_a/bus_d_out/bus_d_oe/bus_din                : address and data
//   bus_ior_l/bus_iow_l/bus_memr_l/bus_memw_l       : active-low strobes
//   bus_aen/bus_rdy                                 : address enable, ready
//-----------------------------------------------------------------------------
interface isa_bus_master_if;
   import isa_pkg::*;

   logic        req_valid;
   logic        req_ready;
   cyc_type_e   req_type;
   logic [19:0] req_addr;
   logic [7:0]  req_wdata;

   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_timeout;

   logic [19:0] bus_a;
   logic [7:0]  bus_d_out;
   logic        bus_d_oe;
   logic [7:0]  bus_din;
   logic        bus_ior_l;
   logic        bus_iow_l;
   logic        bus_memr_l;
   logic        bus_memw_l;
   logic        bus_aen;
   logic        bus_rdy;

   modport master (
      input  req_valid, req_type, req_addr, req_wdata, bus_din, bus_rdy,
      output req_ready, rsp_valid, rsp_rdata, rsp_timeout,
             bus_a, bus_d_out, bus_d_oe,
             bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
   );

   modport slave (
      output req_valid, req_type, req_addr, req_wdata, bus_din, bus_rdy,
      input  req_ready, rsp_valid, rsp_rdata, rsp_timeout,
             bus_a, bus_d_out, bus_d_oe,
             bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l, bus_aen
   );

endinterface

// File: rtl/isa_rdy_sync.sv
//-----------------------------------------------------------------------------
// isa_rdy_sync
// Two-flop synchronizer for the asynchronous responder ready. Both stages
// reset to 1 so the bus reads as "ready" until a responder pulls it low.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   async_i    : raw bus_rdy
//   sync_o     : rdy_sync, safe to use in the clk domain
//-----------------------------------------------------------------------------
module isa_rdy_sync (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic sync_o
);

   logic meta_q;
   logic sync_q;

   // NOTE: non-blocking assignments make sync_q take the old meta_q, which is
   // what gives two real stages instead of one.
   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/isa_bus_master.sv
//-----------------------------------------------------------------------------
// isa_bus_master
// Runs one ISA bus cycle per accepted command: address setup with AEN low,
// a minimum-length strobe stretched by the responder's ready (with a timeout
// abort), then an address/data hold phase, followed by a one-cycle response.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : isa_bus_master_if.master (handshake + bus pins)
// Parameters:
//   SETUP_CYCLES, STROBE_MIN, HOLD_CYCLES : phase lengths in cycles (1-15)
//   RDY_TIMEOUT                           : wait cycles before abort (8-bit)
//-----------------------------------------------------------------------------
module isa_bus_master
   import isa_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES = 2,
   parameter int unsigned STROBE_MIN   = 4,
   parameter int unsigned HOLD_CYCLES  = 2,
   parameter int unsigned RDY_TIMEOUT  = 255
) (
   input  logic             clk,
   input  logic             reset,
   isa_bus_master_if.master bus
);

   // Phase counters count down from N-1 so a phase lasts exactly N cycles.
   localparam logic [3:0] SETUP_LOAD  = 4'(SETUP_CYCLES - 1);
   localparam logic [3:0] STROBE_LOAD = 4'(STROBE_MIN - 1);
   localparam logic [3:0] HOLD_LOAD   = 4'(HOLD_CYCLES - 1);
   localparam logic [7:0] WAIT_LIMIT  = 8'(RDY_TIMEOUT);

   state_e      state_q;
   logic [3:0]  cnt_q;
   logic [7:0]  wait_q;
   cyc_type_e   type_q;
   logic        timeout_q;
   logic [7:0]  rdata_q;

   logic        req_ready_q;
   logic        rsp_valid_q;
   logic [7:0]  rsp_rdata_q;
   logic        rsp_timeout_q;
   logic [19:0] bus_a_q;
   logic [7:0]  bus_d_out_q;
   logic        bus_d_oe_q;
   logic        bus_aen_q;
   strobes_t    strobes_q;

   logic        rdy_sync;
   logic        rdy_done;
   logic        rdy_abort;

   isa_rdy_sync u_rdy_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (bus.bus_rdy),
      .sync_o  (rdy_sync)
   );

   // The strobe phase ends either when the responder is ready (only once the
   // minimum strobe width has elapsed) or when the wait budget runs out.
   always_comb begin
      rdy_done  = 1'b0;
      rdy_abort = 1'b0;
      if (state_q == ST_STROBE) begin
         rdy_done = (cnt_q == 4'd0) && rdy_sync;
      end else if (state_q == ST_WAIT) begin
         rdy_done  = rdy_sync;
         rdy_abort = !rdy_sync && (wait_q == WAIT_LIMIT);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         cnt_q         <= 4'd0;
         wait_q        <= 8'd0;
         type_q        <= CYC_IOR;
         timeout_q     <= 1'b0;
         rdata_q       <= 8'h00;
         req_ready_q   <= 1'b1;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= 8'h00;
         rsp_timeout_q <= 1'b0;
         bus_a_q       <= 20'h0_0000;
         bus_d_out_q   <= 8'h00;
         bus_d_oe_q    <= 1'b0;
         bus_aen_q     <= 1'b1;
         strobes_q     <= STROBES_IDLE;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  type_q      <= bus.req_type;
                  bus_a_q     <= bus.req_addr;
                  bus_d_out_q <= bus.req_wdata;
                  bus_d_oe_q  <= is_write(bus.req_type);
                  bus_aen_q   <= 1'b0;
                  req_ready_q <= 1'b0;
                  timeout_q   <= 1'b0;
                  cnt_q       <= SETUP_LOAD;
                  state_q     <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (cnt_q == 4'd0) begin
                  strobes_q <= strobe_for(type_q);
                  cnt_q     <= STROBE_LOAD;
                  state_q   <= ST_STROBE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            ST_STROBE, ST_WAIT: begin
               if (rdy_done || rdy_abort) begin
                  strobes_q <= STROBES_IDLE;
                  timeout_q <= rdy_abort;
                  rdata_q   <= rdy_abort ? 8'hFF : bus.bus_din;
                  cnt_q     <= HOLD_LOAD;
                  state_q   <= ST_HOLD;
               end else if (state_q == ST_WAIT) begin
                  wait_q <= wait_q + 8'd1;
               end else if (cnt_q == 4'd0) begin
                  wait_q  <= 8'd0;
                  state_q <= ST_WAIT;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            ST_HOLD: begin
               if (cnt_q == 4'd0) begin
                  // Writes report zero data regardless of what was sampled.
                  rsp_valid_q   <= 1'b1;
                  rsp_rdata_q   <= is_write(type_q) ? 8'h00 : rdata_q;
                  rsp_timeout_q <= timeout_q;
                  bus_d_oe_q    <= 1'b0;
                  bus_aen_q     <= 1'b1;
                  req_ready_q   <= 1'b1;
                  state_q       <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_timeout = rsp_timeout_q;
   assign bus.bus_a       = bus_a_q;
   assign bus.bus_d_out   = bus_d_out_q;
   assign bus.bus_d_oe    = bus_d_oe_q;
   assign bus.bus_aen     = bus_aen_q;
   assign bus.bus_ior_l   = strobes_q.ior_l;
   assign bus.bus_iow_l   = strobes_q.iow_l;
   assign bus.bus_memr_l  = strobes_q.memr_l;
   assign bus.bus_memw_l  = strobes_q.memw_l;

endmodule

// File: tb/tb_isa_bus_master.sv
//-----------------------------------------------------------------------------
// tb_isa_bus_master
// Self-checking bench for isa_bus_master. A behavioural responder drives
// bus_rdy/bus_din; expected strobe length, latency and response come from a
// timing model of the bus protocol.
//-----------------------------------------------------------------------------
module tb_isa_bus_master;
   import isa_pkg::*;

   localparam int SETUP   = 2;
   localparam int STROBE  = 4;
   localparam int HOLD    = 2;
   localparam int TIMEOUT = 255;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   logic [7:0] last_rd;
   logic       last_to;

   isa_bus_master_if bus_if ();

   isa_bus_master #(
      .SETUP_CYCLES (SETUP),
      .STROBE_MIN   (STROBE),
      .HOLD_CYCLES  (HOLD),
      .RDY_TIMEOUT  (TIMEOUT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if.master)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   function automatic int strobes_low();
      return int'(!bus_if.bus_ior_l) + int'(!bus_if.bus_iow_l) +
             int'(!bus_if.bus_memr_l) + int'(!bus_if.bus_memw_l);
   endfunction

   function automatic bit sel_low(input logic [1:0] t);
      case (t)
         2'b00:   return !bus_if.bus_ior_l;
         2'b01:   return !bus_if.bus_iow_l;
         2'b10:   return !bus_if.bus_memr_l;
         default: return !bus_if.bus_memw_l;
      endcase
   endfunction

   // Responder model: bus_rdy is low for the first n_low strobe cycles. The
   // master sees it two cycles late, may only end the strobe once the
   // minimum width is reached, and gives up after TIMEOUT+1 wait cycles.
   function automatic int exp_strobe_len(input int n_low, output bit to);
      bit seen;
      to = 1'b0;
      for (int j = STROBE - 1; j < STROBE + TIMEOUT + 8; j++) begin
         seen = (j < 2) ? 1'b1 : ((j - 2) >= n_low);
         if (seen) return j + 1;
         if (j >= STROBE + TIMEOUT) begin
            to = 1'b1;
            return j + 1;
         end
      end
      return -1;
   endfunction

   task automatic idle_inputs();
      bus_if.req_valid = 1'b0;
      bus_if.req_type  = CYC_IOR;
      bus_if.req_addr  = 20'h0;
      bus_if.req_wdata = 8'h00;
      bus_if.bus_din   = 8'h00;
      bus_if.bus_rdy   = 1'b1;
   endtask

   // Runs one transfer starting at the current cycle; returns in the
   // rsp_valid cycle so a caller can present the next request there.
   task automatic do_xfer(input logic [1:0] t, input logic [19:0] a,
                          input logic [7:0] wd, input logic [7:0] din,
                          input int n_low, input string tag);
      int n, exp_l, exp_lat, str_cnt, other_cnt, multi, aen_cnt, doe_cnt;
      int a_err, d_err, first_str, s_seen;
      bit exp_to, wr, got_rsp;
      logic [7:0] exp_rd;

      exp_l   = exp_strobe_len(n_low, exp_to);
      wr      = t[0];
      exp_rd  = wr ? 8'h00 : (exp_to ? 8'hFF : din);
      exp_lat = 1 + SETUP + exp_l + HOLD;

      bus_if.req_valid = 1'b1;
      bus_if.req_type  = cyc_type_e'(t);
      bus_if.req_addr  = a;
      bus_if.req_wdata = wd;
      bus_if.bus_din   = din;
      bus_if.bus_rdy   = 1'b1;

      checks++;
      if (bus_if.req_ready !== 1'b1)
         $display("FAIL %s ready_at_request: got %b expected 1", tag, bus_if.req_ready);

      n = 0; str_cnt = 0; other_cnt = 0; multi = 0; aen_cnt = 0; doe_cnt = 0;
      a_err = 0; d_err = 0; first_str = -1; s_seen = 0; got_rsp = 1'b0;
      while (n < exp_lat + 20) begin
         @(posedge clk);
         #1;
         n++;
         if (n == 1) begin
            checks++;
            if (bus_if.req_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s ready_busy: got %b expected 0", tag, bus_if.req_ready);
            end
            // Request lines change while busy; the latched command must hold.
            bus_if.req_valid = 1'b0;
            bus_if.req_type  = cyc_type_e'($urandom_range(0, 3));
            bus_if.req_addr  = 20'($urandom);
            bus_if.req_wdata = 8'($urandom);
         end
         if (bus_if.rsp_valid === 1'b1) begin
            got_rsp = 1'b1;
            break;
         end
         if (bus_if.bus_aen === 1'b0) aen_cnt++;
         if (bus_if.bus_d_oe === 1'b1) doe_cnt++;
         if (bus_if.bus_a !== a) a_err++;
         if (bus_if.bus_d_out !== wd) d_err++;
         if (strobes_low() > 1) multi++;
         if (sel_low(t)) begin
            str_cnt++;
            if (first_str < 0) first_str = n;
         end else if (strobes_low() != 0) begin
            other_cnt++;
         end
         if (strobes_low() != 0) begin
            s_seen++;
            bus_if.bus_rdy = (s_seen <= n_low) ? 1'b0 : 1'b1;
         end else begin
            bus_if.bus_rdy = 1'b1;
         end
      end
      bus_if.bus_rdy = 1'b1;

      checks++;
      if (!got_rsp || n != exp_lat) begin
         errors++;
         $display("FAIL %s latency: got %0d edges (rsp seen %b) expected %0d", tag, n, got_rsp, exp_lat);
      end
      checks++;
      if (str_cnt != exp_l) begin
         errors++;
         $display("FAIL %s strobe_len: got %0d expected %0d", tag, str_cnt, exp_l);
      end
      checks++;
      if (first_str != 1 + SETUP) begin
         errors++;
         $display("FAIL %s strobe_start: got %0d expected %0d", tag, first_str, 1 + SETUP);
      end
      checks++;
      if (other_cnt != 0 || multi != 0) begin
         errors++;
         $display("FAIL %s wrong_strobe: other %0d multi %0d expected 0 0", tag, other_cnt, multi);
      end
      checks++;
      if (aen_cnt != exp_lat - 1) begin
         errors++;
         $display("FAIL %s aen_low: got %0d expected %0d", tag, aen_cnt, exp_lat - 1);
      end
      checks++;
      if (doe_cnt != (wr ? exp_lat - 1 : 0)) begin
         errors++;
         $display("FAIL %s d_oe_cycles: got %0d expected %0d", tag, doe_cnt, wr ? exp_lat - 1 : 0);
      end
      checks++;
      if (a_err != 0 || d_err != 0) begin
         errors++;
         $display("FAIL %s addr_data_hold: addr errs %0d data errs %0d expected 0 0", tag, a_err, d_err);
      end
      checks++;
      if (bus_if.rsp_rdata !== exp_rd) begin
         errors++;
         $display("FAIL %s rsp_rdata: got %h expected %h", tag, bus_if.rsp_rdata, exp_rd);
      end
      checks++;
      if (bus_if.rsp_timeout !== exp_to) begin
         errors++;
         $display("FAIL %s rsp_timeout: got %b expected %b", tag, bus_if.rsp_timeout, exp_to);
      end
      checks++;
      if (strobes_low() != 0 || bus_if.bus_aen !== 1'b1 || bus_if.bus_d_oe !== 1'b0) begin
         errors++;
         $display("FAIL %s bus_released: strobes low %0d aen %b d_oe %b expected 0 1 0",
                  tag, strobes_low(), bus_if.bus_aen, bus_if.bus_d_oe);
      end
      last_rd = exp_rd;
      last_to = exp_to;
   endtask

   // One cycle after a response: pulse gone, response fields still stable.
   task automatic check_rsp_after(input string tag);
      @(posedge clk);
      #1;
      checks++;
      if (bus_if.rsp_valid !== 1'b0 || bus_if.req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s rsp_pulse: rsp_valid %b req_ready %b expected 0 1",
                  tag, bus_if.rsp_valid, bus_if.req_ready);
      end
      checks++;
      if (bus_if.rsp_rdata !== last_rd || bus_if.rsp_timeout !== last_to) begin
         errors++;
         $display("FAIL %s rsp_stable: got %h/%b expected %h/%b",
                  tag, bus_if.rsp_rdata, bus_if.rsp_timeout, last_rd, last_to);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_if.req_ready !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset handshake: ready %b rsp_valid %b expected 1 0",
                  bus_if.req_ready, bus_if.rsp_valid);
      end
      checks++;
      if (bus_if.rsp_rdata !== 8'h00 || bus_if.rsp_timeout !== 1'b0) begin
         errors++;
         $display("FAIL reset rsp_fields: got %h/%b expected 00/0", bus_if.rsp_rdata, bus_if.rsp_timeout);
      end
      checks++;
      if (bus_if.bus_a !== 20'h0 || bus_if.bus_d_out !== 8'h00 || bus_if.bus_d_oe !== 1'b0) begin
         errors++;
         $display("FAIL reset bus_drive: a %h d %h oe %b expected 0 0 0",
                  bus_if.bus_a, bus_if.bus_d_out, bus_if.bus_d_oe);
      end
      checks++;
      if (strobes_low() != 0 || bus_if.bus_aen !== 1'b1) begin
         errors++;
         $display("FAIL reset strobes: low %0d aen %b expected 0 1", strobes_low(), bus_if.bus_aen);
      end
      reset = 1'b0;
   endtask

   task automatic test_iow();
      do_xfer(2'b01, 20'h003D8, 8'h29, 8'h00, 0, "iow_3d8");
      check_rsp_after("iow_3d8");
   endtask

   task automatic test_ior();
      do_xfer(2'b00, 20'h003DA, 8'h00, 8'hF9, 0, "ior_3da");
      check_rsp_after("ior_3da");
   endtask

   task automatic test_wait_states();
      do_xfer(2'b10, 20'hB8000, 8'h00, 8'h5A, 10, "memr_wait");
      check_rsp_after("memr_wait");
   endtask

   task automatic test_timeout();
      do_xfer(2'b11, 20'hC0123, 8'hA5, 8'h77, 1000, "memw_timeout");
      check_rsp_after("memw_timeout");
      do_xfer(2'b00, 20'h00060, 8'h00, 8'h3C, 0, "ior_after_timeout");
      check_rsp_after("ior_after_timeout");
   endtask

   task automatic test_back_to_back();
      do_xfer(2'b01, 20'h003D4, 8'h0E, 8'h00, 0, "b2b_first");
      do_xfer(2'b01, 20'h003D5, 8'h4F, 8'h00, 0, "b2b_second");
      check_rsp_after("b2b_second");
   endtask

   task automatic test_random();
      logic [1:0]  t;
      logic [19:0] a;
      logic [7:0]  wd, din;
      int          n_low;
      for (int i = 0; i < 6; i++) begin
         t     = 2'($urandom_range(0, 3));
         a     = 20'($urandom);
         wd    = 8'($urandom);
         din   = 8'($urandom);
         n_low = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 8));
         do_xfer(t, a, wd, din, n_low, "random");
         check_rsp_after("random");
      end
   endtask

   task automatic test_reset_mid();
      bit seen;
      int pulses;
      seen = 1'b0;
      pulses = 0;
      bus_if.req_valid = 1'b1;
      bus_if.req_type  = CYC_MEMR;
      bus_if.req_addr  = 20'hB8010;
      bus_if.bus_din   = 8'h11;
      for (int n = 1; n <= 10; n++) begin
         @(posedge clk);
         #1;
         bus_if.req_valid = 1'b0;
         if (bus_if.bus_memr_l === 1'b0) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL reset_mid strobe_seen: got 0 expected 1");
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (strobes_low() != 0 || bus_if.bus_aen !== 1'b1 || bus_if.rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid release: strobes low %0d aen %b rsp %b expected 0 1 0",
                  strobes_low(), bus_if.bus_aen, bus_if.rsp_valid);
      end
      reset = 1'b0;
      for (int n = 0; n < 15; n++) begin
         @(posedge clk);
         #1;
         if (bus_if.rsp_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0) begin
         errors++;
         $display("FAIL reset_mid no_rsp: got %0d pulses expected 0", pulses);
      end
   endtask

   initial begin
      reset = 1'b1;
      idle_inputs();
      test_reset();
      test_iow();
      test_ior();
      test_wait_states();
      test_timeout();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/isa_bus_master.md
ISA_BUS_MASTER -- requirements
Module: isa_bus_master

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2, meaning address/AEN setup cycles before the strobe (range 1-15).
REQ-002 SHALL have parameter STROBE_MIN, default 4, meaning the minimum strobe-low cycles (range 1-15).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2, meaning address/data hold cycles after the strobe rises (range 1-15).
REQ-004 SHALL have parameter RDY_TIMEOUT, default 255, meaning the maximum WAIT cycles before abort (8-bit).
REQ-005 clk  in  1  sole clock; reset is synchronous and active-high.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 req_valid  in  1  command request.
REQ-008 req_ready  out  1  command accepted when high with req_valid.
REQ-009 req_type  in  2  00=IOR, 01=IOW, 10=MEMR, 11=MEMW.
REQ-010 req_addr  in  20  bus address; req_wdata  in  8  write data.
REQ-011 rsp_valid  out  1  one-cycle completion pulse; rsp_rdata  out  8  read data; rsp_timeout  out  1  cycle aborted.
REQ-012 bus_a  out  20 / bus_d_out  out  8 / bus_d_oe  out  1  address, write data, data drive enable.
REQ-013 bus_din  in  8  read data returned by the responder.
REQ-014 bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l  out  1 each  active-low strobes.
REQ-015 bus_aen  out  1  high when idle, low during a cycle; bus_rdy  in  1  asynchronous responder ready.

Function
REQ-016 FSM states SHALL be IDLE, SETUP, STROBE, WAIT, HOLD; req_ready SHALL be high only in IDLE.
REQ-017 IDLE: on req_valid, SHALL latch type/addr/wdata, load the counter with SETUP_CYCLES-1, and go to SETUP.
REQ-018 SETUP: bus_a=latched addr, bus_aen=0, all strobes high; when counter=0, SHALL load STROBE_MIN-1 and go to STROBE.
REQ-019 STROBE/WAIT: exactly the one strobe selected by type SHALL be low; never more than one strobe low in any cycle.
REQ-020 STROBE at counter=0: if rdy_sync=1, SHALL capture bus_din (reads) and go to HOLD; else go to WAIT with the wait counter cleared.
REQ-021 WAIT: wait counter SHALL increment each cycle; rdy_sync=1 SHALL capture bus_din and go to HOLD; wait counter=RDY_TIMEOUT with rdy_sync=0 SHALL set the timeout flag, load rdata=8'hFF, and go to HOLD.
REQ-022 HOLD: strobes high, bus_a and bus_d_out held, bus_aen=0, for HOLD_CYCLES cycles; then IDLE with rsp_valid=1 for exactly that first IDLE cycle.
REQ-023 rsp_rdata/rsp_timeout SHALL remain stable until the next rsp_valid; rsp_rdata=8'h00 for writes.
REQ-024 bus_d_oe SHALL be high from SETUP through HOLD for IOW/MEMW only; bus_d_out=latched wdata.
REQ-025 Latency with bus_rdy held high: rsp_valid SHALL be high 1+SETUP_CYCLES+STROBE_MIN+HOLD_CYCLES edges after the accept edge (9 at defaults).
REQ-026 A request presented in the rsp_valid cycle SHALL be accepted (back-to-back, no dead cycle).
REQ-027 bus_rdy SHALL pass through a 2-flop synchronizer (rdy_sync); the raw input SHALL never be used.
REQ-028 req_* changes while req_ready=0 SHALL have no effect.

Reset
REQ-029 reset SHALL force IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_timeout=0, bus_a=0, bus_d_out=0, bus_d_oe=0, all strobes=1, bus_aen=1, sync flops=1, counters=0.
REQ-030 reset asserted mid-cycle SHALL release the strobe at the next edge and SHALL NOT produce rsp_valid for the aborted cycle.

Structure
REQ-031 Shared package isa_pkg SHALL hold the cycle-type encoding (IOR/IOW/MEMR/MEMW) and the FSM state enum.
REQ-032 Sub-module isa_rdy_sync (2-flop synchronizer, reset value 1) SHALL be instantiated once.

Verification
REQ-033 IOW addr 3D8h data 29h, bus_rdy=1 -> bus_iow_l low 4 cycles, bus_d_oe high, rsp_valid 9 edges after accept, rsp_timeout=0.
REQ-034 IOR addr 3DAh, responder drives bus_din=F9h -> rsp_rdata=F9h, only bus_ior_l toggles, bus_aen low for 8 cycles.
REQ-035 MEMR addr B8000h, bus_rdy low for 10 cycles after strobe -> strobe extended, rsp_valid after rdy_sync rises, data correct.
REQ-036 MEMW with bus_rdy stuck low -> WAIT reaches 255, rsp_timeout=1, rsp_rdata=00h, strobe released, next request accepted.
REQ-037 Two back-to-back requests (IOW 3D4h then IOW 3D5h) -> second accepted in the rsp_valid cycle, no strobe overlap.
REQ-038 reset asserted during STROBE of MEMR -> strobes high and bus_aen=1 next edge, no rsp_valid.
